dynamic_range_sweeper: RTL and testbench

//   Synthesizable amplitude-sweep controller and peak meter for FIR dynamic-range characterisation.

---
 rtl/dynamic_range_sweeper_if.sv | 22 ++
 rtl/dynamic_range_sweeper.sv | 189 ++++++++++++++++++
 tb/tb_dynamic_range_sweeper.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dynamic_range_sweeper_if.sv
// Result channel of the amplitude sweeper: one record per amplitude step, valid/ready handshake.
interface dynamic_range_sweeper_if #(
  parameter int DATA_WIDTH = 32,
  parameter int STEP_WIDTH = 4
);
  logic                         result_valid;
  logic                         result_ready;
  logic        [STEP_WIDTH-1:0] result_step;
  logic signed [DATA_WIDTH-1:0] result_max;
  logic signed [DATA_WIDTH-1:0] result_min;
  logic        [DATA_WIDTH-1:0] result_peak;

  modport master (
    output result_valid, result_step, result_max, result_min, result_peak,
    input  result_ready
  );

  modport slave (
    input  result_valid, result_step, result_max, result_min, result_peak,
    output result_ready
  );
endinterface

// File: rtl/dynamic_range_sweeper.sv
// Amplitude-sweep controller and peak meter; result valid 1 cycle after the last measured sample.
// Result is held indefinitely under backpressure while incoming samples are ignored.
module dynamic_range_sweeper #(
  parameter int DATA_WIDTH     = 32,
  parameter int AMP_WIDTH      = 16,
  parameter int NUM_STEPS      = 10,
  parameter int AMP_MAX        = 65535,
  parameter int SETTLE_SAMPLES = 64,
  parameter int MEAS_SAMPLES   = 480
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  output logic        [AMP_WIDTH-1:0]  amplitude,
  output logic                         busy,
  output logic                         sweep_done,
  dynamic_range_sweeper_if.master      res
);

  localparam int STEP_W   = $clog2(NUM_STEPS + 1);
  localparam int AMP_STEP = AMP_MAX / NUM_STEPS;
  localparam int PROD_W   = AMP_WIDTH + $clog2(NUM_STEPS);
  localparam int CNT_MAX  = (SETTLE_SAMPLES > MEAS_SAMPLES) ? SETTLE_SAMPLES : MEAS_SAMPLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
  localparam logic [CNT_W-1:0]  MEAS_LAST   = CNT_W'(MEAS_SAMPLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NUM_STEPS - 1);

  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic        [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, REPORT, DONE} state_t;

  state_t state_q, state_nxt;

  logic        [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic        [STEP_W-1:0]     step_q, step_nxt, step_inc;
  logic        [AMP_WIDTH-1:0]  amp_nxt;
  logic signed [DATA_WIDTH-1:0] max_q, max_nxt, meas_max;
  logic signed [DATA_WIDTH-1:0] min_q, min_nxt, meas_min;
  logic        [DATA_WIDTH-1:0] peak_q, peak_nxt, meas_peak;
  logic        [DATA_WIDTH-1:0] sample_abs;
  logic                         first_sample;
  logic                         res_load;

  logic        [STEP_W-1:0]     rstep_q;
  logic signed [DATA_WIDTH-1:0] rmax_q, rmin_q;
  logic        [DATA_WIDTH-1:0] rpeak_q;

  // Most-negative input has no positive counterpart, so it clips to full-scale positive.
  always_comb begin
    if (sample_in == MOST_NEG)
      sample_abs = MOST_POS;
    else if (sample_in[DATA_WIDTH-1])
      sample_abs = $unsigned(-sample_in);
    else
      sample_abs = $unsigned(sample_in);
  end

  assign first_sample = (cnt_q == '0);
  assign meas_max     = (first_sample || sample_in > max_q) ? sample_in : max_q;
  assign meas_min     = (first_sample || sample_in < min_q) ? sample_in : min_q;
  assign meas_peak    = (first_sample || sample_abs > peak_q) ? sample_abs : peak_q;
  assign step_inc     = step_q + STEP_W'(1);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    step_nxt  = step_q;
    amp_nxt   = amplitude;
    max_nxt   = max_q;
    min_nxt   = min_q;
    peak_nxt  = peak_q;
    res_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          step_nxt  = '0;
          amp_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (SETTLE_SAMPLES == 0) begin
          state_nxt = MEASURE;
          cnt_nxt   = '0;
        end else if (sample_valid) begin
          if (cnt_q == SETTLE_LAST) begin
            state_nxt = MEASURE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      MEASURE: begin
        if (sample_valid) begin
          max_nxt  = meas_max;
          min_nxt  = meas_min;
          peak_nxt = meas_peak;
          if (cnt_q == MEAS_LAST) begin
            res_load  = 1'b1;
            state_nxt = REPORT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      REPORT: begin
        if (res.result_ready) begin
          if (step_q == LAST_STEP) begin
            state_nxt = DONE;
            amp_nxt   = '0;
          end else begin
            state_nxt = SETTLE;
            step_nxt  = step_inc;
            amp_nxt   = AMP_WIDTH'(PROD_W'(step_inc) * PROD_W'(AMP_STEP));
            cnt_nxt   = '0;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        amp_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides start and a same-cycle handshake accept.
    if (abort) begin
      state_nxt = IDLE;
      amp_nxt   = '0;
      cnt_nxt   = '0;
      step_nxt  = '0;
      res_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      step_q    <= '0;
      amplitude <= '0;
      max_q     <= '0;
      min_q     <= '0;
      peak_q    <= '0;
      rstep_q   <= '0;
      rmax_q    <= '0;
      rmin_q    <= '0;
      rpeak_q   <= '0;
    end else begin
      cnt_q     <= cnt_nxt;
      step_q    <= step_nxt;
      amplitude <= amp_nxt;
      max_q     <= max_nxt;
      min_q     <= min_nxt;
      peak_q    <= peak_nxt;
      if (res_load) begin
        rstep_q <= step_q;
        rmax_q  <= meas_max;
        rmin_q  <= meas_min;
        rpeak_q <= meas_peak;
      end
    end
  end

  assign busy             = (state_q != IDLE);
  assign sweep_done       = (state_q == DONE);
  assign res.result_valid = (state_q == REPORT);
  assign res.result_step  = rstep_q;
  assign res.result_max   = rmax_q;
  assign res.result_min   = rmin_q;
  assign res.result_peak  = rpeak_q;

endmodule

// File: tb/tb_dynamic_range_sweeper.sv
// Directed bench: table-driven sweep vectors plus hand-timed backpressure, abort, reset and zero-settle sequences.
module tb_dynamic_range_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 4 steps of 250, settle 2, measure 4
  logic               a_start, a_abort, a_v, a_busy, a_done;
  logic signed [31:0] a_x;
  logic [15:0]        a_amp;
  dynamic_range_sweeper_if #(.DATA_WIDTH(32), .STEP_WIDTH(3)) ifa ();

  dynamic_range_sweeper #(
    .DATA_WIDTH(32), .AMP_WIDTH(16), .NUM_STEPS(4), .AMP_MAX(1000),
    .SETTLE_SAMPLES(2), .MEAS_SAMPLES(4)
  ) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .sample_in(a_x), .sample_valid(a_v), .amplitude(a_amp),
    .busy(a_busy), .sweep_done(a_done), .res(ifa)
  );

  // DUT B: 2 steps of 50, no settle window, measure 3
  logic               b_start, b_abort, b_v, b_busy, b_done;
  logic signed [31:0] b_x;
  logic [15:0]        b_amp;
  dynamic_range_sweeper_if #(.DATA_WIDTH(32), .STEP_WIDTH(2)) ifb ();

  dynamic_range_sweeper #(
    .DATA_WIDTH(32), .AMP_WIDTH(16), .NUM_STEPS(2), .AMP_MAX(100),
    .SETTLE_SAMPLES(0), .MEAS_SAMPLES(3)
  ) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .sample_in(b_x), .sample_valid(b_v), .amplitude(b_amp),
    .busy(b_busy), .sweep_done(b_done), .res(ifb)
  );

  typedef struct {
    logic [3:0][31:0]   s;
    logic signed [31:0] emax;
    logic signed [31:0] emin;
    logic [31:0]        epeak;
    logic [15:0]        eamp;
  } vec_t;

  vec_t tv [4];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [31:0] s0, s1, s2, s3,
                              input logic [31:0] emax, emin, epeak,
                              input logic [15:0] eamp);
    vec_t v;
    v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    v.emax = emax; v.emin = emin; v.epeak = epeak; v.eamp = eamp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_result(input string tag, input int i);
    chk({tag, "_valid"}, ifa.result_valid, 1'b1);
    chk({tag, "_step"},  ifa.result_step, 3'(i));
    chk({tag, "_max"},   ifa.result_max, tv[i].emax);
    chk({tag, "_min"},   ifa.result_min, tv[i].emin);
    chk({tag, "_peak"},  ifa.result_peak, tv[i].epeak);
    chk({tag, "_amp"},   a_amp, tv[i].eamp);
  endtask

  // Settle window of two valid junk samples, then the four measured samples of vector i.
  task automatic a_run_step(input int i);
    a_v = 1'b1;
    a_x = 32'sd123456;
    tick();
    a_x = -32'sd123456;
    tick();
    chk("settle_amp", a_amp, tv[i].eamp);
    chk("settle_nvalid", ifa.result_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      a_x = tv[i].s[k];
      tick();
    end
  endtask

  logic frozen, seen_valid, seen_done;

  initial begin
    tv[0] = mk(32'd5, -32'sd7, 32'd3, -32'sd2, 32'd5, -32'sd7, 32'd7, 16'd0);
    tv[1] = mk(32'h80000000, 32'd100, -32'sd1, 32'd0, 32'd100, 32'h80000000, 32'h7FFFFFFF, 16'd250);
    tv[2] = mk(32'h7FFFFFFF, 32'd1, 32'd2, 32'd3, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 16'd500);
    tv[3] = mk(-32'sd1, -32'sd1, -32'sd1, -32'sd1, -32'sd1, -32'sd1, 32'd1, 16'd750);

    rst = 1'b1;
    a_start = 0; a_abort = 0; a_v = 0; a_x = 0; ifa.result_ready = 0;
    b_start = 0; b_abort = 0; b_v = 0; b_x = 0; ifb.result_ready = 0;
    repeat (3) tick();
    chk("rst_amp", a_amp, 16'd0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_valid", ifa.result_valid, 1'b0);
    chk("rst_max", ifa.result_max, 32'd0);
    chk("rst_peak", ifa.result_peak, 32'd0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_b_busy", b_busy, 1'b0);
    rst = 1'b0;
    tick();

    // Full sweep, ready held high, valid every cycle
    ifa.result_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("sweep_busy", a_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a_run_step(i);
      chk_a_result("sweep", i);
      a_x = 32'sd777;
      if (i == 1) a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("sweep_acc_nvalid", ifa.result_valid, 1'b0);
      chk("sweep_done_pulse", a_done, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("done_amp", a_amp, 16'd0);
    tick();
    chk("done_once", a_done, 1'b0);
    chk("done_idle", a_busy, 1'b0);

    // Backpressure on step 0 with sample_valid gaps in both windows
    ifa.result_ready = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_v = 0; tick();
    a_v = 1; a_x = 32'sd900; tick();
    a_v = 0; tick();
    a_v = 1; a_x = -32'sd900; tick();
    for (int k = 0; k < 4; k++) begin
      a_v = 1'b0; a_x = 32'h80000000; tick();
      a_v = 1'b1; a_x = tv[0].s[k]; tick();
    end
    frozen = 1'b1;
    for (int c = 0; c < 20; c++) begin
      a_v = 1'b1;
      a_x = $urandom();
      tick();
      if (ifa.result_valid !== 1'b1 || ifa.result_max !== tv[0].emax ||
          ifa.result_min !== tv[0].emin || ifa.result_peak !== tv[0].epeak ||
          a_amp !== 16'd0 || ifa.result_step !== 3'd0)
        frozen = 1'b0;
    end
    chk("bp_frozen", frozen, 1'b1);
    chk_a_result("bp", 0);
    ifa.result_ready = 1'b1;
    tick();
    chk("bp_acc_nvalid", ifa.result_valid, 1'b0);
    chk("bp_acc_amp", a_amp, 16'd250);
    a_run_step(1);
    chk_a_result("bp_next", 1);
    tick();
    chk("pre_abort_amp", a_amp, 16'd500);

    // Abort in step 2 settle window
    a_abort = 1'b1;
    a_x = 32'sd1;
    tick();
    a_abort = 1'b0;
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_amp", a_amp, 16'd0);
    chk("abort_valid", ifa.result_valid, 1'b0);
    seen_valid = 1'b0;
    seen_done  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      a_v = 1'b1;
      a_x = $urandom();
      tick();
      seen_valid |= ifa.result_valid;
      seen_done  |= a_done;
    end
    chk("abort_no_result", seen_valid, 1'b0);
    chk("abort_no_done", seen_done, 1'b0);

    // Reset held 3 cycles in the middle of step 1 measurement
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_run_step(0);
    tick();
    a_v = 1'b1; a_x = 32'sd11; tick(); tick(); tick();
    a_x = 32'sd12; tick();
    chk("mid_meas_amp", a_amp, 16'd250);
    rst = 1'b1;
    tick();
    chk("rst_mid_amp", a_amp, 16'd0);
    chk("rst_mid_busy", a_busy, 1'b0);
    chk("rst_mid_valid", ifa.result_valid, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_after_busy", a_busy, 1'b0);
    chk("rst_after_max", ifa.result_max, 32'd0);
    a_v = 1'b0;

    // Zero-length settle window; start while busy is ignored
    ifb.result_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_v = 1'b0;
    tick();
    chk("b_busy", b_busy, 1'b1);
    chk("b_amp0", b_amp, 16'd0);
    b_v = 1; b_x = 32'sd9;  tick();
    b_start = 1; b_x = -32'sd3; tick();
    b_start = 0; b_x = 32'sd4;  tick();
    chk("b0_valid", ifb.result_valid, 1'b1);
    chk("b0_step", ifb.result_step, 2'd0);
    chk("b0_max", ifb.result_max, 32'sd9);
    chk("b0_min", ifb.result_min, -32'sd3);
    chk("b0_peak", ifb.result_peak, 32'd9);
    b_v = 1'b0;
    tick();
    chk("b1_amp", b_amp, 16'd50);
    chk("b1_nvalid", ifb.result_valid, 1'b0);
    tick();
    b_v = 1; b_x = -32'sd20; tick();
    b_x = 32'sd0;  tick();
    b_x = 32'sd15; tick();
    b_v = 1'b0;
    chk("b1_valid", ifb.result_valid, 1'b1);
    chk("b1_step", ifb.result_step, 2'd1);
    chk("b1_max", ifb.result_max, 32'sd15);
    chk("b1_min", ifb.result_min, -32'sd20);
    chk("b1_peak", ifb.result_peak, 32'd20);
    chk("b1_amp_meas", b_amp, 16'd50);
    tick();
    chk("b_done", b_done, 1'b1);
    chk("b_done_amp", b_amp, 16'd0);
    tick();
    chk("b_done_once", b_done, 1'b0);
    chk("b_idle", b_busy, 1'b0);
    b_start = 1'b1;
    b_abort = 1'b1;
    tick();
    b_start = 1'b0;
    b_abort = 1'b0;
    chk("b_start_abort_idle", b_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
